// File: rtl/safety_error_handler.sv
// Fault-reaction controller: turns the safety monitor's active-low alarm into an
// interrupt plus safe-state request, escalating to a locked reset request on ack timeout.
module safety_error_handler #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int RST_PULSE   = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sf_error_alarm_i,
    input  logic [4:0]       sf_error_code_i,
    input  logic             ack_i,
    output logic             irq_o,
    output logic             safe_state_o,
    output logic             rst_req_o,
    output logic [4:0]       evt_code_o,
    output logic [4:0]       accum_code_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [1:0]       state_o
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
    localparam logic [TW-1:0] TMR_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ALERT    = 2'd1,
        ESCALATE = 2'd2,
        LOCKED   = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] ack_tmr;
    logic [PW-1:0] pulse_cnt;
    logic [4:0]    faulted;
    logic          ack_valid;

    always_comb begin
        faulted   = ~sf_error_code_i;
        ack_valid = ack_i & sf_error_alarm_i;
    end

    assign state_o = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ack_tmr      <= '0;
            pulse_cnt    <= '0;
            irq_o        <= 1'b0;
            safe_state_o <= 1'b0;
            rst_req_o    <= 1'b0;
            evt_code_o   <= '0;
            accum_code_o <= '0;
            err_cnt_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!sf_error_alarm_i) begin
                        state        <= ALERT;
                        evt_code_o   <= faulted;
                        accum_code_o <= accum_code_o | faulted;
                        if (err_cnt_o != '1)
                            err_cnt_o <= err_cnt_o + 1'b1;
                        ack_tmr      <= '0;
                        irq_o        <= 1'b1;
                        safe_state_o <= 1'b1;
                    end
                end
                ALERT: begin
                    accum_code_o <= accum_code_o | faulted;
                    // A valid ack on the last ALERT cycle takes priority over escalation.
                    if (ack_valid) begin
                        state        <= IDLE;
                        irq_o        <= 1'b0;
                        safe_state_o <= 1'b0;
                    end else if (ack_tmr == TMR_LAST) begin
                        state     <= ESCALATE;
                        pulse_cnt <= '0;
                        rst_req_o <= 1'b1;
                    end else begin
                        ack_tmr <= ack_tmr + 1'b1;
                    end
                end
                ESCALATE: begin
                    accum_code_o <= accum_code_o | faulted;
                    if (pulse_cnt == PULSE_LAST) begin
                        state     <= LOCKED;
                        rst_req_o <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    accum_code_o <= accum_code_o | faulted;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/safety_error_handler.md
# safety_error_handler

Fault-reaction controller at the receiving end of the SoC safety monitor. It takes the monitor's active-low overall alarm and its active-low per-source error code, then raises a software interrupt and a safe-state request. It records which sources faulted and waits for a software acknowledge. If software does not acknowledge within a bounded time, it escalates to a system reset request and locks. It sits between the safety monitor and the interrupt controller / reset generator.

## Interface
Parameters:
- ACK_TIMEOUT, 1024: maximum ALERT cycles without a valid acknowledge before escalation; must be ≥2.
- RST_PULSE, 16: length of rst_req_o pulse in cycles; must be ≥1.
- CNT_W, 8: width of the event counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- sf_error_alarm_i  in  1  overall alarm from safety monitor; active-low (0 = fault).
- sf_error_code_i  in  5  per-source alarm levels; bit n = source n+1; active-low.
- ack_i  in  1  software acknowledge, single-cycle pulse.
- irq_o  out  1  fault interrupt, level.
- safe_state_o  out  1  request for peripherals to enter safe state.
- rst_req_o  out  1  system reset request pulse.
- evt_code_o  out  5  active-high sources faulted at entry of the current/last event (~sf_error_code_i, captured).
- accum_code_o  out  5  sticky OR of all active-high source bits seen while not IDLE.
- err_cnt_o  out  CNT_W  number of fault events; saturating.
- state_o  out  2  FSM state: 0 IDLE, 1 ALERT, 2 ESCALATE, 3 LOCKED.

## Operation
- All outputs are registered. Reset value of every output is 0, with state_o = IDLE and internal timers = 0.
- Fault source decoding: faulted = ~sf_error_code_i (5 bits).
- **IDLE**
  - If sf_error_alarm_i==0: go to ALERT.
  - On that transition: evt_code_o ← faulted; accum_code_o |= faulted; err_cnt_o += 1, saturating at 2^CNT_W−1; ack timer ← 0.
  - ack_i is ignored.
- **ALERT**
  - irq_o=1, safe_state_o=1.
  - accum_code_o |= faulted every cycle.
  - The ack timer increments each ALERT cycle.
  - A valid ack is ack_i==1 AND sf_error_alarm_i==1 in the same cycle. A valid ack → IDLE; irq_o and safe_state_o go to 0.
  - ack_i while sf_error_alarm_i==0 is ignored.
  - If the timer == ACK_TIMEOUT−1 and there is no valid ack this cycle → ESCALATE, and the pulse counter ← 0.
  - Alarm returning high without an ack does not leave ALERT.
- **ESCALATE**
  - rst_req_o=1, irq_o=1, safe_state_o=1.
  - Held for exactly RST_PULSE cycles, then → LOCKED.
  - ack_i is ignored.
- **LOCKED**
  - irq_o=1, safe_state_o=1, rst_req_o=0.
  - Terminal state; only rst exits. ack_i and alarm inputs are ignored, except that accum_code_o continues accumulating.
- evt_code_o and err_cnt_o hold their values in all states except on IDLE→ALERT entry.
- accum_code_o is cleared only by rst.

## Timing
- Detection latency: an alarm sampled low at edge N gives state_o=ALERT, irq_o=1, safe_state_o=1 and updated evt_code_o/err_cnt_o visible after edge N (one cycle).
- ALERT duration without a valid ack: exactly ACK_TIMEOUT cycles. rst_req_o rises after the ACK_TIMEOUT-th ALERT edge.
- A valid ack on the final ALERT cycle wins over the timeout → IDLE.
- Valid ack at edge M: irq_o=0 after edge M. If the alarm is low again at edge M+1, a new event is counted.
- rst_req_o is high for RST_PULSE consecutive cycles, then LOCKED.
- rst asserted in any state, including mid-ESCALATE pulse: all outputs are 0 after that edge. rst dominates all other inputs.

## Test plan
- **Reset:** assert rst 2 cycles with sf_error_alarm_i=0 → all outputs 0 and state_o=0 during and directly after reset; ALERT is entered on the first edge after rst is released.
- **Single event, acknowledged** (ACK_TIMEOUT=8):
  - Stimulus: alarm=0, code=5'b11011 for 1 cycle, then alarm=1, code=5'b11111; ack_i at ALERT cycle 3.
  - Required: state 1, evt_code_o=5'b00100, err_cnt_o=1, irq_o=1; after the ack edge state 0 and irq_o=0; evt_code_o stays 00100.
- **Timeout escalation** (ACK_TIMEOUT=8, RST_PULSE=4):
  - Stimulus: alarm held 0, no ack.
  - Required: ALERT for exactly 8 cycles; rst_req_o=1 for exactly 4 cycles; then state 3 with irq_o=1 and rst_req_o=0; ack_i is ignored; rst returns all outputs to 0.
- **Ack qualification:**
  - ack_i while alarm=0 at ALERT cycle 2 → still ALERT.
  - alarm=1 and ack_i on ALERT cycle 8 (the last) → IDLE, rst_req_o never asserts.
- **Accumulation:**
  - Stimulus: code=5'b11110 on entry, then 5'b01110 during ALERT.
  - Required: evt_code_o=5'b00001, accum_code_o=5'b10001.
- **Counter saturation** (CNT_W=2): 5 ack'd events → err_cnt_o sequence 1, 2, 3, 3, 3.
